// File: rtl/sync_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Brief   : Plain multi-flop synchronizer for one asynchronous level.
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Pure shift: no logic between stages so metastability only has to settle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/signal_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : signal_debounce
// Brief   : Synchronizer plus stability-count filter with glitch statistics.
// Revision: 1.0 - initial release
// ============================================================================
module signal_debounce #(
    parameter int   SYNC_STAGES      = 2,
    parameter int   STABLE_CYCLES    = 4,
    parameter logic RESET_LEVEL      = 1'b0,
    parameter int   GLITCH_CNT_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        signal_in,
    output logic                        signal_out,
    output logic                        busy,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_count
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("signal_debounce: STABLE_CYCLES must be >= 1");
    end

    logic                        w_sync;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        out_q, out_d;
    logic [GLITCH_CNT_WIDTH-1:0] glitch_q, glitch_d;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync_chain (
        .clock (clock),
        .reset (reset),
        .d     (signal_in),
        .q     (w_sync)
    );

    // With STABLE_CYCLES == 1 the last-count value is 0, so a difference is
    // accepted on the first edge it is seen and the counter never moves.
    always_comb begin
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = glitch_q;
        if (w_sync != out_q) begin
            if (cnt_q == C_CNT_LAST) begin
                out_d = w_sync;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = '0;
            if (glitch_q != '1) begin
                glitch_d = glitch_q + GLITCH_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            out_q    <= RESET_LEVEL;
            glitch_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    assign signal_out   = out_q;
    assign busy         = (cnt_q != '0);
    assign glitch_count = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_signal_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_signal_debounce
// Brief   : Table, directed and random checks of three debounce configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_signal_debounce;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sig_in = 1'b1;
    logic       out_a, busy_a;
    logic [7:0] gc_a;
    logic       out_g, busy_g;
    logic [1:0] gc_g;
    logic       out_s, busy_s;
    logic [7:0] gc_s;

    int checks = 0;
    int errors = 0;

    always #1 clock = ~clock;

    signal_debounce u_dut_a (
        .clock(clock), .reset(reset), .signal_in(sig_in),
        .signal_out(out_a), .busy(busy_a), .glitch_count(gc_a)
    );

    signal_debounce #(.GLITCH_CNT_WIDTH(2)) u_dut_g (
        .clock(clock), .reset(reset), .signal_in(sig_in),
        .signal_out(out_g), .busy(busy_g), .glitch_count(gc_g)
    );

    signal_debounce #(.STABLE_CYCLES(1)) u_dut_s (
        .clock(clock), .reset(reset), .signal_in(sig_in),
        .signal_out(out_s), .busy(busy_s), .glitch_count(gc_s)
    );

    // Reference: a delay line for the synchronizer and, per configuration, the
    // length of the current run of synchronized samples that disagree with the output.
    int  stab[3] = '{4, 4, 1};
    int  gmax[3] = '{255, 3, 255};
    bit  m_out[3];
    int  m_run[3];
    int  m_gl[3];
    bit  m_pipe[$] = '{1'b0, 1'b0};

    always @(posedge clock) begin
        bit s;
        if (reset) begin
            m_pipe = '{1'b0, 1'b0};
            for (int i = 0; i < 3; i++) begin
                m_out[i] = 1'b0; m_run[i] = 0; m_gl[i] = 0;
            end
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(sig_in);
            for (int i = 0; i < 3; i++) begin
                if (s != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= stab[i]) begin
                        m_out[i] = s;
                        m_run[i] = 0;
                    end
                end else begin
                    if (m_run[i] > 0 && m_gl[i] < gmax[i]) m_gl[i]++;
                    m_run[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model out_a",  32'(out_a),  32'(m_out[0]));
        chk("model busy_a", 32'(busy_a), 32'(m_run[0] != 0));
        chk("model gc_a",   32'(gc_a),   32'(m_gl[0]));
        chk("model out_g",  32'(out_g),  32'(m_out[1]));
        chk("model busy_g", 32'(busy_g), 32'(m_run[1] != 0));
        chk("model gc_g",   32'(gc_g),   32'(m_gl[1]));
        chk("model out_s",  32'(out_s),  32'(m_out[2]));
        chk("model busy_s", 32'(busy_s), 32'(m_run[2] != 0));
        chk("model gc_s",   32'(gc_s),   32'(m_gl[2]));
    endtask

    task automatic step(input logic r, input logic d);
        reset  = r;
        sig_in = d;
        @(posedge clock);
        #0.5;
        check_model();
    endtask

    typedef struct {
        logic rst;
        logic din;
        logic eout;
        logic ebusy;
        int   egc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic d,
                                input logic o, input logic b, input int g);
        vec_t v;
        v.rst = r; v.din = d; v.eout = o; v.ebusy = b; v.egc = g;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        bit hist[$];
        int left;
        bit lvl;
        logic r;

        // reset, clean rise, fall, 3-cycle reject, 4-cycle accept, reset mid-count, reversal
        add(3, 1, 1, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0);
        add(2, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 1);
        add(2, 0, 1, 0, 0, 1);
        add(2, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 0, 1);
        add(3, 0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 0, 1);
        add(2, 0, 1, 0, 0, 1);
        add(2, 0, 1, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(3, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].din);
            chk($sformatf("tbl[%0d] out", i),  32'(out_a),  32'(tbl[i].eout));
            chk($sformatf("tbl[%0d] busy", i), 32'(busy_a), 32'(tbl[i].ebusy));
            chk($sformatf("tbl[%0d] gc", i),   32'(gc_a),   32'(tbl[i].egc));
        end

        // Glitch counter saturation on the 2-bit configuration
        step(1, 0);
        repeat (3) step(0, 0);
        for (int k = 1; k <= 5; k++) begin
            repeat (2) step(0, 1);
            repeat (5) step(0, 0);
            chk($sformatf("sat gc_g %0d", k), 32'(gc_g), (k < 3) ? k : 3);
            chk($sformatf("sat out_g %0d", k), 32'(out_g), 0);
            chk($sformatf("sat gc_a %0d", k), 32'(gc_a), k);
        end

        // STABLE_CYCLES=1: single-cycle pulses pass through two edges late
        for (int i = 0; i < 20; i++) begin
            bit d;
            d = (i % 4 == 1);
            step(0, d);
            hist.push_back(d);
            if (i >= 2) chk($sformatf("s1 out %0d", i), 32'(out_s), 32'(hist[i-2]));
            chk($sformatf("s1 busy %0d", i), 32'(busy_s), 0);
        end

        // Random runs of 1..7 cycles with occasional reset
        left = 0;
        lvl  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 7);
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, lvl);
            left--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
